// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done request bus for the iterative multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div0, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div0, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [2*WIDTH:0]   acc_q;
  logic [2*WIDTH:0]   acc_d;
  logic [CW-1:0]      cnt_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               bzero_q;
  logic               busy_q;
  logic               done_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               div0_d;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Operands are reduced to magnitudes at acceptance; signs are re-applied at FIX.
  always_comb begin
    a_neg = bus.op[0] & bus.a[WIDTH-1];
    b_neg = bus.op[0] & bus.b[WIDTH-1];
    mag_a = a_neg ? -bus.a : bus.a;
    mag_b = b_neg ? -bus.b : bus.b;
  end

  // Multiply: the low half holds the remaining multiplier bits and shifts right.
  // Divide: the upper W+1 bits hold the partial remainder, quotient bits enter at the bottom.
  always_comb begin
    addend    = acc_q[0] ? mag_b_q : '0;
    mul_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, addend};
    div_rem   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_rem >= {1'b0, mag_b_q};
    div_trial = div_rem - {1'b0, mag_b_q};
    acc_d     = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    if (op_q[1]) begin
      acc_d = div_ge ? {div_trial, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-1:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = qneg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo      = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    div0_d   = 1'b0;
    if (op_q[1]) begin
      if (bzero_q) begin
        hi_d   = a_q;
        lo_d   = '1;
        div0_d = 1'b1;
      end else begin
        hi_d   = rem;
        lo_d   = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            mag_b_q <= mag_b;
            acc_q   <= {{(WIDTH+1){1'b0}}, mag_a};
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg & bus.op[1];
            bzero_q <= (bus.b == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          div0_q  <= div0_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
